// File: rtl/poly_small_gauss_sampler.sv
// Discrete-Gaussian small-polynomial sampler: K CDT draws per coefficient, range
// rejection, LANES coefficients per ready/valid beat, end-of-polynomial parity.
module poly_small_gauss_sampler #(
    parameter int LOGN  = 9,
    parameter int F_BIT = (LOGN == 9) ? 7 : 6,
    parameter int LANES = 1,
    parameter int TBL_N = 27,
    parameter int TBL_W = 63
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     rng_valid,
    input  logic [127:0]             rng,
    output logic                     rng_extract,
    input  logic [TBL_N*TBL_W-1:0]   cdt,
    input  logic                     f_ready,
    output logic                     f_valid,
    output logic [LANES*F_BIT-1:0]   f,
    output logic [LOGN-1:0]          f_idx,
    output logic                     poly_done,
    output logic                     parity
);
    localparam int K      = 1 << (10 - LOGN);
    localparam int ACC_W  = $clog2(K * TBL_N + 1) + 1;
    localparam int CNT_W  = $clog2(K) + 1;
    localparam int MAG_W  = $clog2(TBL_N + 1);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LIM    = 1 << (F_BIT - 1);
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'((1 << LOGN) - LANES);

    typedef enum logic [2:0] {S_IDLE, S_SAMPLE, S_CHECK, S_OUT, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           hp_q, hp_d;
    logic [LANE_W-1:0]              lane_q, lane_d;
    logic [LANES-1:0][F_BIT-1:0]    lbuf_q, lbuf_d;
    logic [LOGN-1:0]                idx_q, idx_d;
    logic                           par_q, par_d;

    logic [63:0]                    draw;
    logic [62:0]                    ent;
    logic [MAG_W-1:0]               mag;
    logic signed [ACC_W-1:0]        samp;
    logic signed [31:0]             acc_w;
    logic                           reject;

    // Magnitude is a thermometer count over the ascending table.
    always_comb begin
        draw = hp_q ? rng[127:64] : rng[63:0];
        mag  = '0;
        ent  = '0;
        for (int i = 0; i < TBL_N; i++) begin
            ent = '0;
            ent[TBL_W-1:0] = cdt[i*TBL_W +: TBL_W];
            if (ent <= draw[62:0]) mag = mag + MAG_W'(1);
        end
        samp = ACC_W'(mag);
        if (draw[63]) samp = -samp;
        acc_w  = 32'(acc_q);
        reject = (acc_w >= LIM) || (acc_w <= -LIM);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        hp_d        = hp_q;
        lane_d      = lane_q;
        lbuf_d      = lbuf_q;
        idx_d       = idx_q;
        par_d       = par_q;
        rng_extract = 1'b0;
        if (!ena) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            hp_d    = 1'b0;
            lane_d  = '0;
            lbuf_d  = '0;
            idx_d   = '0;
            par_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_SAMPLE;
                S_SAMPLE: begin
                    if (rng_valid) begin
                        rng_extract = hp_q;
                        hp_d        = ~hp_q;
                        acc_d       = acc_q + samp;
                        cnt_d       = cnt_q + CNT_W'(1);
                        if (int'(cnt_q) == K - 1) state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    // A rejected sum just restarts; the half pointer keeps its place.
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                    if (!reject) begin
                        for (int j = 0; j < LANES; j++)
                            if (j == int'(lane_q)) lbuf_d[j] = acc_w[F_BIT-1:0];
                        par_d = par_q ^ acc_w[0];
                        if (int'(lane_q) == LANES - 1) begin
                            lane_d  = '0;
                            state_d = S_OUT;
                        end else begin
                            lane_d = lane_q + LANE_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (f_ready) begin
                        idx_d   = idx_q + LOGN'(LANES);
                        state_d = (idx_q == LAST_IDX) ? S_DONE : S_SAMPLE;
                    end
                end
                S_DONE: begin
                    par_d   = 1'b0;
                    state_d = S_SAMPLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            hp_q    <= 1'b0;
            lane_q  <= '0;
            lbuf_q  <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            lane_q  <= lane_d;
            lbuf_q  <= lbuf_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
        end
    end

    assign f_valid   = (state_q == S_OUT);
    assign poly_done = (state_q == S_DONE);
    assign f         = lbuf_q;
    assign f_idx     = idx_q;
    assign parity    = par_q;

endmodule

// File: tb/tb_poly_small_gauss_sampler.sv
// Randomized bench for poly_small_gauss_sampler (LOGN=8, LANES=4) against a
// coefficient-stream model built from the draw/reject rules.
module tb_poly_small_gauss_sampler;
    localparam int LOGN  = 8;
    localparam int LANES = 4;
    localparam int F_BIT = 6;
    localparam int TBL_N = 27;
    localparam int TBL_W = 63;
    localparam int K     = 4;
    localparam int N     = 256;
    localparam int BEATS = N / LANES;
    localparam int NW    = 16384;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   ena = 1'b0;
    logic                   rng_valid = 1'b0;
    logic [127:0]           rng = '0;
    logic                   rng_extract;
    logic [TBL_N*TBL_W-1:0] cdt = '0;
    logic                   f_ready = 1'b0;
    logic                   f_valid;
    logic [LANES*F_BIT-1:0] f;
    logic [LOGN-1:0]        f_idx;
    logic                   poly_done;
    logic                   parity;

    poly_small_gauss_sampler #(.LOGN(LOGN), .LANES(LANES), .TBL_N(TBL_N), .TBL_W(TBL_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rng_valid(rng_valid), .rng(rng),
        .rng_extract(rng_extract), .cdt(cdt), .f_ready(f_ready), .f_valid(f_valid),
        .f(f), .f_idx(f_idx), .poly_done(poly_done), .parity(parity)
    );

    always #5 clk = ~clk;

    logic [127:0] words [NW];
    logic [62:0]  tbl [TBL_N];
    int wp = 0, gap_pct = 0;
    int n_chk = 0, n_err = 0;
    int mh = 0, exp_idx = 0, beats = 0, dones = 0;
    bit mpar = 1'b0, rnd_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input logic [62:0] v);
        int m = 0;
        for (int i = 0; i < TBL_N; i++) if (tbl[i] <= v) m++;
        return m;
    endfunction

    // Next accepted coefficient from the half-word stream starting at mh.
    task automatic model_coef(output int c);
        int acc;
        logic [127:0] w;
        logic [63:0] r;
        do begin
            acc = 0;
            for (int k = 0; k < K; k++) begin
                w = words[mh / 2];
                r = (mh % 2 == 1) ? w[127:64] : w[63:0];
                acc += r[63] ? -mag_of(r[62:0]) : mag_of(r[62:0]);
                mh++;
            end
        end while (acc >= (1 << (F_BIT - 1)) || acc <= -(1 << (F_BIT - 1)));
        c = acc;
    endtask

    function automatic logic [63:0] gen_half();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(7))
            0: r[62:0] = tbl[$urandom_range(TBL_N - 1)];
            1: r[62:0] = tbl[$urandom_range(TBL_N - 1)] - 63'd1;
            default: r[62:0] = r[62:0] >> $urandom_range(8);
        endcase
        return r;
    endfunction

    // RNG source: present word wp, advance on each extract.
    initial begin
        bit ext;
        forever begin
            @(negedge clk);
            rng = words[wp];
            rng_valid = ($urandom_range(99) >= gap_pct);
            #1 ext = rng_extract;
            @(posedge clk);
            if (ext) wp++;
        end
    end

    // Output monitor and scoreboard.
    initial begin
        bit stall_q = 1'b0;
        logic [LANES*F_BIT-1:0] sf, ef;
        logic [LOGN-1:0] si;
        int c;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ena) begin
                if (stall_q) begin
                    check("stall_f", f, sf);
                    check("stall_idx", f_idx, si);
                end
                if (f_valid) check("no_draw_in_out", rng_extract, 0);
                if (f_valid && f_ready) begin
                    for (int j = 0; j < LANES; j++) begin
                        model_coef(c);
                        ef[j*F_BIT +: F_BIT] = c[F_BIT-1:0];
                        mpar ^= c[0];
                    end
                    check("beat_f", f, ef);
                    check("beat_idx", f_idx, exp_idx);
                    check("words_used", wp, mh / 2);
                    exp_idx = (exp_idx + LANES) % N;
                    beats++;
                end
                if (poly_done) begin
                    check("parity", parity, mpar);
                    check("beats_per_poly", beats, BEATS);
                    mpar = 1'b0;
                    beats = 0;
                    dones++;
                end
                stall_q = f_valid && !f_ready;
                sf = f;
                si = f_idx;
            end else begin
                stall_q = 1'b0;
            end
        end
    end

    task automatic pack_cdt();
        for (int i = 0; i < TBL_N; i++) cdt[i*TBL_W +: TBL_W] = tbl[i];
    endtask

    // Idle the DUT, load a fresh word stream, then re-enable from f_idx 0.
    task automatic start_run(input int mode);
        @(negedge clk);
        ena = 1'b0;
        repeat (2) @(negedge clk);
        if (mode == 2) begin
            tbl[0] = 63'({$urandom} << 26) + 63'd1;
            for (int i = 1; i < TBL_N; i++) tbl[i] = tbl[i-1] + 63'({$urandom} << 26) + 63'd1;
        end else begin
            for (int i = 0; i < TBL_N; i++) tbl[i] = 63'(i + 1) << 56;
        end
        pack_cdt();
        for (int i = 0; i < NW; i++) begin
            case (mode)
                0: words[i] = (i < 2) ? {2{64'h4000_0000_0000_0000}} : '0;
                1: words[i] = {64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000};
                default: words[i] = {gen_half(), gen_half()};
            endcase
        end
        wp = 0; mh = 0; mpar = 1'b0; exp_idx = 0; beats = 0;
        @(negedge clk);
        ena = 1'b1;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (dones < target && t < 40000) begin
            @(negedge clk);
            if (rnd_ready) f_ready = 1'($urandom_range(1));
            t++;
        end
        check("done_timeout", dones >= target, 1);
    endtask

    task automatic wait_beats(input int target);
        int t = 0;
        while (beats < target && t < 20000) begin
            @(negedge clk);
            if (rnd_ready) f_ready = 1'($urandom_range(1));
            t++;
        end
        check("beats_timeout", beats >= target, 1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, f_valid, 0);
        check({tag, "_f"}, f, 0);
        check({tag, "_idx"}, f_idx, 0);
        check({tag, "_done"}, poly_done, 0);
        check({tag, "_parity"}, parity, 0);
        check({tag, "_extract"}, rng_extract, 0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < TBL_N; i++) tbl[i] = 63'(i + 1) << 56;
        pack_cdt();
        for (int i = 0; i < NW; i++) words[i] = {$urandom, $urandom, $urandom, $urandom};
        #1 rst_n = 1'b0;
        #2 check_cleared("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        check("idle_no_extract", wp, 0);
        check("idle_no_valid", f_valid, 0);

        // Rejection of the first sum, then a 10-cycle downstream stall.
        start_run(0);
        t = 0;
        while (!f_valid && t < 200) begin
            @(negedge clk);
            #3 t++;
        end
        check("first_valid", f_valid, 1);
        check("rej_first_idx", f_idx, 0);
        check("rej_first_f", f, 0);
        check("rej_words", wp, 10);
        repeat (10) @(negedge clk);
        #3 check("stall_words", wp, 10);
        @(negedge clk);
        f_ready = 1'b1;
        @(negedge clk);
        #3;
        check("bp_adv_idx", f_idx, 4);
        check("bp_adv_valid", f_valid, 0);
        wait_done(1);

        // Opposite-sign saturated halves cancel to zero.
        rnd_ready = 1'b1;
        start_run(1);
        wait_done(2);

        // Random table, random words, RNG gaps, random ready, abort mid-poly.
        gap_pct = 30;
        start_run(2);
        wait_done(3);
        wait_beats(25);
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        #3 check_cleared("abort");
        mh = 2 * wp; mpar = 1'b0; exp_idx = 0; beats = 0;
        @(negedge clk);
        ena = 1'b1;
        wait_done(4);

        // Asynchronous reset in the middle of sampling.
        repeat (150) begin
            @(negedge clk);
            f_ready = 1'($urandom_range(1));
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_cleared("async_rst");
        @(negedge clk);
        ena = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
